mult_div_sequencer: RTL and testbench
=====================================

Name: mult_div_sequencer

Overview:
- Iterative signed/unsigned multiply and divide engine with its own FSM; replaces the free-running multiplier/divider pair feeding HI/LO.
- The main control unit issues a one-cycle start with the operation code and waits for done.
- The block owns the HI/LO result registers.
- Sits beside the ALU, fed from the A/B operand registers; HI/LO outputs go to the write-back mux.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe, sampled only in IDLE
op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
flush  input  1  synchronous abort (exception path)
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle completion pulse
div_by_zero  output  1  valid with done; set for DIV/DIVU with b==0
hi  output  WIDTH  HI register: product upper half / remainder
lo  output  WIDTH  LO register: product lower half / quotient

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: state IDLE; busy 0, done 0, div_by_zero 0; hi and lo 0; internal counter and shift registers 0.
- States:
  - IDLE: start=1 latches a, b and op, and goes to PREP.
  - PREP (1 cycle):
    - Signed ops: take absolute values; record the result signs (product: sa^sb; quotient: sa^sb; remainder: sa).
    - Unsigned ops: pass the operands through unchanged.
    - DIV/DIVU with b==0: go to DONE with div_by_zero=1.
    - Otherwise: clear the counter and go to RUN.
  - RUN (WIDTH cycles, counter 0..WIDTH-1):
    - Multiply: shift-add, 2*WIDTH-bit accumulator.
    - Divide: restoring, one quotient bit per cycle.
    - At count WIDTH-1, go to FIX.
  - FIX (1 cycle): negate the results per the recorded signs; write hi and lo; go to DONE.
  - DONE (1 cycle): done=1, then return to IDLE.
- Latency: done rises on the (WIDTH+2)th rising edge after the edge that sampled start, i.e. 34 edges for WIDTH=32. For a divide-by-zero, done rises on the 2nd edge.
- hi and lo change only on the FIX->DONE edge. They hold their values otherwise, including across a divide-by-zero, a flush and an ignored start.
- div_by_zero is cleared on every accepted start and holds its value until the next accepted start.
- Ignored starts: start outside IDLE is ignored; there is no queueing. A start during DONE is also ignored; the requester re-issues it once busy=0.
- Divide semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0. Natural wrap; no trap.
- Multiply semantics: MULT gives the signed 64-bit product; MULTU the unsigned product.
- flush:
  - In any non-IDLE state: go to IDLE on the next edge. No done pulse; hi, lo and div_by_zero are unchanged.
  - In IDLE: flush overrides start, and the request is not accepted.
- Reset mid-operation: immediate IDLE; hi and lo are cleared.
- Opcode: op is captured at start and held internally. Changes on op, a or b during busy have no effect.

Decomposition:
- Shared package (cpu_pkg): op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the FSM state encoding (IDLE, PREP, RUN, FIX, DONE). The control unit uses the same op constants and maps funct to op.
- One sub-module is natural: md_iter_core.
  - Holds the accumulator/remainder shift registers.
  - Performs one multiply or divide step per enable.
  - Exposes the raw unsigned results.
- The FSM, sign handling and HI/LO registers stay in mult_div_sequencer.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done at edge 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; div_by_zero=0.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=0xFFFFFFFF, b=0x10 -> lo=0x0FFFFFFF, hi=0x0000000F.
- DIV a=5, b=0 with prior hi/lo=0x1234/0x5678 -> done at edge 2, div_by_zero=1, hi/lo unchanged. Also: DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT, assert start again at cycle 10 with other operands -> second request ignored and first result correct. Then flush at RUN cycle 15 -> busy=0 next cycle, no done pulse, hi/lo unchanged.
- Assert reset at RUN cycle 20 -> busy, done, hi and lo are 0 immediately. After release, a new MULT 3*4 -> lo=12, hi=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the multiply/divide engine and its control unit.
// Holds the HI/LO operation codes, the sequencer state encoding and small op helpers.
// The control unit maps funct to these same op constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_t;

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_sequencer_if.sv
// Request/result bundle between the control unit (master) and the multiply/divide engine (slave).
// start/op/a/b/flush flow from the control unit; busy/done/div_by_zero/hi/lo flow back.
// There is no queueing: the master re-issues a start once busy is low.
interface mult_div_sequencer_if #(parameter int WIDTH = 32);
  import cpu_pkg::*;

  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/md_iter_core.sv
// Unsigned iterative datapath: one shift-add multiply step or one restoring divide step per i_step.
// Latency: WIDTH steps after i_load; raw product in {o_hi,o_lo}, or remainder in o_hi and quotient in o_lo.
// No backpressure: the sequencer owns pacing through i_load/i_step.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic             r_is_div;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_fits;
  logic [WIDTH-1:0] w_next_hi;
  logic [WIDTH-1:0] w_next_lo;

  // Multiply: add multiplicand into the upper half when the current multiplier bit is set, carry kept.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  // Divide: shift the next dividend bit into the partial remainder and trial-subtract the divisor.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  // Partial remainder is always below the divisor, so the trial result's top bit is a clean borrow flag.
  assign w_div_fits  = ~w_div_diff[WIDTH];

  // Select the next accumulator value for the active operation.
  always_comb begin
    w_next_hi = r_hi;
    w_next_lo = r_lo;
    if (r_is_div) begin
      w_next_hi = w_div_fits ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_next_lo = {r_lo[WIDTH-2:0], w_div_fits};
    end else begin
      w_next_hi = w_mul_sum[WIDTH:1];
      w_next_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Load operands at the start of a run, then advance one step per enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_hi     <= '0;
      r_lo     <= i_is_div ? i_opa : i_opb;
      r_opnd   <= i_is_div ? i_opb : i_opa;
      r_is_div <= i_is_div;
    end else if (i_step) begin
      r_hi     <= w_next_hi;
      r_lo     <= w_next_lo;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mult_div_sequencer.sv
// Signed/unsigned multiply/divide sequencer owning the HI/LO registers.
// Latency: done WIDTH+2 edges after the accepted start; divide-by-zero completes straight after PREP.
// No queueing: starts outside IDLE are dropped; flush aborts to IDLE with no done and HI/LO untouched.
module mult_div_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_div_sequencer_if.slave  io_md
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  md_state_t        r_state;
  md_state_t        w_next;
  md_op_t           r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_dbz;

  logic             w_accept;
  logic             w_is_div;
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_core_hi;
  logic [WIDTH-1:0] w_core_lo;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  // flush wins over start so an exception never launches a new operation.
  assign w_accept = (r_state == IDLE) && io_md.start && !io_md.flush;
  assign w_is_div = md_is_div(r_op);
  assign w_signed = md_is_signed(r_op);
  assign w_sa     = w_signed & r_a[WIDTH-1];
  assign w_sb     = w_signed & r_b[WIDTH-1];
  // Most-negative operand maps to itself, which is the correct unsigned magnitude.
  assign w_abs_a  = w_sa ? -r_a : r_a;
  assign w_abs_b  = w_sb ? -r_b : r_b;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (w_is_div),
    .i_opa    (w_abs_a),
    .i_opb    (w_abs_b),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  // Next state and core controls; flush overrides everything outside IDLE.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    unique case (r_state)
      IDLE: if (w_accept) w_next = PREP;
      PREP: begin
        if (w_is_div && (r_b == '0)) begin
          w_next = DONE;
        end else begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) w_next = FIX;
      end
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (io_md.flush && (r_state != IDLE)) begin
      w_next = IDLE;
      w_load = 1'b0;
      w_step = 1'b0;
    end
  end

  // Apply recorded signs: the product negates as one 2*WIDTH value, quotient and remainder separately.
  always_comb begin
    w_fix_hi = w_core_hi;
    w_fix_lo = w_core_lo;
    if (w_is_div) begin
      if (r_neg_lo) w_fix_lo = -w_core_lo;
      if (r_neg_hi) w_fix_hi = -w_core_hi;
    end else if (r_neg_lo) begin
      {w_fix_hi, w_fix_lo} = -{w_core_hi, w_core_lo};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Operand capture, sign flags, iteration count, div-by-zero flag and HI/LO write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= MD_MULT;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= io_md.op;
        r_a   <= io_md.a;
        r_b   <= io_md.b;
        r_dbz <= 1'b0;
      end
      if ((r_state == PREP) && (w_next == DONE)) r_dbz <= 1'b1;
      if (w_load) begin
        r_cnt    <= '0;
        r_neg_lo <= w_sa ^ w_sb;
        r_neg_hi <= w_is_div ? w_sa : (w_sa ^ w_sb);
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == FIX) && (w_next == DONE)) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end
  end

  assign io_md.busy        = (r_state != IDLE);
  assign io_md.done        = (r_state == DONE);
  assign io_md.div_by_zero = r_dbz;
  assign io_md.hi          = r_hi;
  assign io_md.lo          = r_lo;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: directed cases plus randomized ops against an arithmetic model.
// Stimulus pushes expected {hi, lo, div_by_zero, latency}; a negedge monitor pops and compares on done.
// Aborted operations (flush, reset) push nothing, so any done they produce is flagged.
module tb_mult_div_sequencer;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int          cyc       = 0;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          done_cnt  = 0;
  int          t_start   = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;
  logic        m_dbz = 1'b0;

  mult_div_sequencer_if #(.WIDTH(32)) md ();

  mult_div_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io_md (md)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference: plain 64-bit arithmetic. SV '/' truncates toward zero and '%' follows the dividend sign.
  function automatic exp_t model(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb;
    logic [63:0] ua, ub, r64, q64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.dbz = 1'b0;
    e.lat = 34;
    case (op)
      MD_MULT:  begin r64 = sa * sb; e.hi = r64[63:32]; e.lo = r64[31:0]; end
      MD_MULTU: begin r64 = ua * ub; e.hi = r64[63:32]; e.lo = r64[31:0]; end
      MD_DIV: begin
        if (b == 32'd0) begin
          e.dbz = 1'b1;
          e.lat = 1;  // done on the edge after PREP: second edge counting the sampling edge
        end else begin
          q64 = sa / sb; r64 = sa % sb;
          e.lo = q64[31:0]; e.hi = r64[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          e.dbz = 1'b1;
          e.lat = 1;
        end else begin
          q64 = ua / ub; r64 = ua % ub;
          e.lo = q64[31:0]; e.hi = r64[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && md.done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("hi", 64'(md.hi), 64'(mon_e.hi));
        chk("lo", 64'(md.lo), 64'(mon_e.lo));
        chk("div_by_zero", 64'(md.div_by_zero), 64'(mon_e.dbz));
        chk("latency", 64'(cyc - t_start), 64'(mon_e.lat));
      end
    end
  end

  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t e;
    @(negedge clk);
    md.start = 1'b1; md.op = op; md.a = a; md.b = b;
    if (track) begin
      e = model(op, a, b);
      sb_q.push_back(e);
      m_hi = e.hi; m_lo = e.lo; m_dbz = e.dbz;
    end else begin
      m_dbz = 1'b0;  // the accepted start clears div_by_zero even if the op is later aborted
    end
    @(posedge clk); #1;
    t_start  = cyc;
    md.start = 1'b0;
    // Scramble request inputs while busy; they must be ignored.
    md.op = md_op_t'($urandom_range(0, 3)); md.a = $urandom; md.b = $urandom;
  endtask

  task automatic wait_done(input int prev);
    int i;
    i = 0;
    while (done_cnt == prev && i < 60) begin
      @(posedge clk);
      i++;
    end
    if (done_cnt == prev) begin
      n_checks++;
      $display("FAIL done_timeout: no done within 60 cycles, expected one");
    end
    #1;
  endtask

  task automatic do_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    int prev;
    prev = done_cnt;
    issue(op, a, b, 1'b1);
    wait_done(prev);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          prev;
    md_op_t      rop;
    logic [31:0] ra, rb;
    md.start = 1'b0; md.op = MD_MULT; md.a = '0; md.b = '0; md.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(md.busy), 64'd0);
    chk("reset_done", 64'(md.done), 64'd0);
    chk("reset_dbz", 64'(md.div_by_zero), 64'd0);
    chk("reset_hi", 64'(md.hi), 64'd0);
    chk("reset_lo", 64'(md.lo), 64'd0);
    @(negedge clk) reset = 1'b0;

    do_op(MD_MULT, 32'd7, 32'hFFFF_FFFD);
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    do_op(MD_DIVU, 32'hFFFF_FFFF, 32'h10);
    do_op(MD_DIVU, 32'h5678_1234, 32'h0001_0000);  // leaves hi=0x1234, lo=0x5678
    do_op(MD_DIV, 32'd5, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("dbz_hold", 64'(md.div_by_zero), 64'd1);
    chk("dbz_hi_kept", 64'(md.hi), 64'h1234);
    chk("dbz_lo_kept", 64'(md.lo), 64'h5678);
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    // Second start mid-run must be dropped.
    prev = done_cnt;
    issue(MD_MULT, 32'h0001_0003, 32'h0000_0101, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk); md.start = 1'b1; md.op = MD_DIVU; md.a = 32'd100; md.b = 32'd7;
    @(posedge clk); #1; md.start = 1'b0;
    wait_done(prev);

    // Flush in RUN cycle 15.
    prev = done_cnt;
    issue(MD_MULT, 32'h0123_4567, 32'h89AB_CDEF, 1'b0);
    repeat (16) @(posedge clk); #1;
    chk("busy_in_run", 64'(md.busy), 64'd1);
    @(negedge clk); md.flush = 1'b1;
    @(posedge clk); #1; md.flush = 1'b0;
    chk("flush_busy", 64'(md.busy), 64'd0);
    repeat (40) @(posedge clk); #1;
    chk("flush_no_done", 64'(done_cnt), 64'(prev));
    chk("flush_hi", 64'(md.hi), 64'(m_hi));
    chk("flush_lo", 64'(md.lo), 64'(m_lo));
    chk("flush_dbz", 64'(md.div_by_zero), 64'(m_dbz));

    // flush beats start in IDLE.
    @(negedge clk); md.start = 1'b1; md.flush = 1'b1; md.op = MD_MULT; md.a = 32'd9; md.b = 32'd9;
    @(posedge clk); #1; md.start = 1'b0; md.flush = 1'b0;
    chk("flush_idle_busy", 64'(md.busy), 64'd0);

    // Reset in RUN cycle 20.
    issue(MD_MULT, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    repeat (21) @(posedge clk);
    @(negedge clk); reset = 1'b1; #1;
    chk("rst_busy", 64'(md.busy), 64'd0);
    chk("rst_done", 64'(md.done), 64'd0);
    chk("rst_hi", 64'(md.hi), 64'd0);
    chk("rst_lo", 64'(md.lo), 64'd0);
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    @(negedge clk); reset = 1'b0;
    do_op(MD_MULT, 32'd3, 32'd4);

    for (int k = 0; k < 40; k++) begin
      rop = md_op_t'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      do_op(rop, ra, rb);
    end

    repeat (5) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
